// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// controller states and the per-stage stall/flush masks it drives.
package hazard_pkg;

  localparam int IFP = 0;
  localparam int IFR = 1;
  localparam int IDC = 2;
  localparam int IDR = 3;
  localparam int EXB = 4;
  localparam int MEM = 5;

  localparam int BASE_STAGES = 6;
  localparam int REM_W       = 4;

  typedef enum logic [1:0] {S_RUN, S_LU, S_REDIR, S_MEMW} state_e;

  typedef logic [BASE_STAGES-1:0] stage_vec_t;

  // Front end is everything ahead of execute; it holds on load-use and refetches on redirect.
  localparam stage_vec_t FE_MASK     = stage_vec_t'((1 << IFP) | (1 << IFR) | (1 << IDC) | (1 << IDR));
  localparam stage_vec_t MEMW_STALL  = stage_vec_t'(FE_MASK | (1 << EXB) | (1 << MEM));
  localparam stage_vec_t BR_FLUSH    = stage_vec_t'((1 << IFR) | (1 << IDC) | (1 << IDR) | (1 << EXB));
  localparam stage_vec_t REDIR_FLUSH = stage_vec_t'((1 << IFR) | (1 << IDC) | (1 << IDR));
  localparam stage_vec_t LU_FLUSH    = stage_vec_t'(1 << EXB);

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter used for the hazard controller's stall/flush statistics.
module hazard_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle redirect flush and
// whole-pipe freeze on data-memory waits, plus saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NUM_STAGES   = 6,
  parameter int REDIRECT_CYC = 1,
  parameter int LOAD_USE_CYC = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_taken_EXB,
  input  logic [XLEN-1:0]       branch_target_EXB,
  input  logic                  load_EXB,
  input  logic [4:0]            rd_EXB,
  input  logic [4:0]            rs1_IDR,
  input  logic [4:0]            rs2_IDR,
  input  logic                  rs1_use_IDR,
  input  logic                  rs2_use_IDR,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ack_MEM,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  branch_taken_IFP,
  output logic [XLEN-1:0]       branch_target_IFP,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [REM_W-1:0] REDIR_REM = REM_W'(REDIRECT_CYC - 1);
  localparam logic [REM_W-1:0] LU_REM    = REM_W'(LOAD_USE_CYC - 1);

  state_e           state_q;
  state_e           saved_q;
  state_e           eff_state;
  logic [REM_W-1:0] rem_q;
  logic             memw;
  logic             lu;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             take;
  stage_vec_t       stall_v;
  stage_vec_t       flush_v;

  // While frozen on memory the pre-wait state is what governs the ack cycle.
  always_comb begin
    memw      = mem_req_MEM & ~mem_ack_MEM;
    rs1_hit   = rs1_use_IDR && (rs1_IDR == rd_EXB);
    rs2_hit   = rs2_use_IDR && (rs2_IDR == rd_EXB);
    lu        = load_EXB && (rd_EXB != 5'd0) && (rs1_hit || rs2_hit);
    eff_state = (state_q == S_MEMW) ? saved_q : state_q;
    stall_v   = '0;
    flush_v   = '0;
    take      = 1'b0;
    if (rst_n) begin
      if (memw) begin
        stall_v = MEMW_STALL;
      end else if (branch_taken_EXB) begin
        take    = 1'b1;
        flush_v = BR_FLUSH;
      end else if (lu || (eff_state == S_LU)) begin
        stall_v = FE_MASK;
        flush_v = LU_FLUSH;
      end else if (eff_state == S_REDIR) begin
        flush_v = REDIR_FLUSH;
      end
    end
  end

  assign stall             = NUM_STAGES'(stall_v);
  assign flush             = NUM_STAGES'(flush_v);
  assign branch_taken_IFP  = take;
  assign branch_target_IFP = branch_target_EXB;
  assign busy              = rst_n && (state_q != S_RUN);

  // A memory wait freezes the remaining-cycle count; a new branch or load-use restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      saved_q <= S_RUN;
      rem_q   <= '0;
    end else if (memw) begin
      state_q <= S_MEMW;
      if (state_q != S_MEMW) begin
        saved_q <= state_q;
      end
    end else if (branch_taken_EXB) begin
      state_q <= (REDIR_REM != '0) ? S_REDIR : S_RUN;
      rem_q   <= REDIR_REM;
    end else if (lu) begin
      state_q <= (LU_REM != '0) ? S_LU : S_RUN;
      rem_q   <= LU_REM;
    end else if ((eff_state == S_LU) || (eff_state == S_REDIR)) begin
      rem_q   <= rem_q - REM_W'(1);
      state_q <= (rem_q <= REM_W'(1)) ? S_RUN : eff_state;
    end else begin
      state_q <= S_RUN;
    end
  end

  hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|stall_v),
    .count (stall_cnt)
  );

  hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (|flush_v),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl with REDIRECT_CYC=3, LOAD_USE_CYC=2, CNT_W=4.
module tb_hazard_ctrl;

  localparam int XLEN = 64;
  localparam int NS   = 6;
  localparam int CW   = 4;

  localparam logic [NS-1:0]   ZERO = 6'b000000;
  localparam logic [NS-1:0]   FE   = 6'b001111;
  localparam logic [NS-1:0]   LUF  = 6'b010000;
  localparam logic [NS-1:0]   BRF  = 6'b011110;
  localparam logic [NS-1:0]   RDF  = 6'b001110;
  localparam logic [NS-1:0]   ALL  = 6'b111111;
  localparam logic [XLEN-1:0] TGT  = 64'h0000_0000_8000_0040;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            branch_taken_EXB = 1'b0;
  logic [XLEN-1:0] branch_target_EXB = '0;
  logic            load_EXB = 1'b0;
  logic [4:0]      rd_EXB = '0;
  logic [4:0]      rs1_IDR = '0;
  logic [4:0]      rs2_IDR = '0;
  logic            rs1_use_IDR = 1'b0;
  logic            rs2_use_IDR = 1'b0;
  logic            mem_req_MEM = 1'b0;
  logic            mem_ack_MEM = 1'b0;
  logic [NS-1:0]   stall;
  logic [NS-1:0]   flush;
  logic            branch_taken_IFP;
  logic [XLEN-1:0] branch_target_IFP;
  logic            busy;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   flush_cnt;

  hazard_ctrl #(
    .XLEN(XLEN), .NUM_STAGES(NS), .REDIRECT_CYC(3), .LOAD_USE_CYC(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_taken_EXB(branch_taken_EXB), .branch_target_EXB(branch_target_EXB),
    .load_EXB(load_EXB), .rd_EXB(rd_EXB), .rs1_IDR(rs1_IDR), .rs2_IDR(rs2_IDR),
    .rs1_use_IDR(rs1_use_IDR), .rs2_use_IDR(rs2_use_IDR),
    .mem_req_MEM(mem_req_MEM), .mem_ack_MEM(mem_ack_MEM),
    .stall(stall), .flush(flush),
    .branch_taken_IFP(branch_taken_IFP), .branch_target_IFP(branch_target_IFP),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            bt;
    logic [XLEN-1:0] tgt;
    logic            ld;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            u1;
    logic            u2;
    logic            req;
    logic            ack;
  } stim_t;

  typedef struct packed {
    logic [NS-1:0]   stall;
    logic [NS-1:0]   flush;
    logic            bt;
    logic [XLEN-1:0] tgt;
    logic            busy;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_sc = '0;
  logic [CW-1:0] exp_fc = '0;

  function automatic stim_t mk(logic bt, logic [XLEN-1:0] tgt, logic ld, logic [4:0] rd,
                               logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic req, logic ack);
    stim_t s;
    s.bt = bt; s.tgt = tgt; s.ld = ld; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = u1; s.u2 = u2; s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic exp_t ex(logic [NS-1:0] st, logic [NS-1:0] fl, logic bt,
                              logic [XLEN-1:0] tgt, logic bz);
    exp_t e;
    e.stall = st; e.flush = fl; e.bt = bt; e.tgt = tgt; e.busy = bz;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    branch_taken_EXB  = s.bt;
    branch_target_EXB = s.tgt;
    load_EXB          = s.ld;
    rd_EXB            = s.rd;
    rs1_IDR           = s.rs1;
    rs2_IDR           = s.rs2;
    rs1_use_IDR       = s.u1;
    rs2_use_IDR       = s.u2;
    mem_req_MEM       = s.req;
    mem_ack_MEM       = s.ack;
  endtask

  // Counter model: one count per cycle in which any stall/flush bit is expected.
  task automatic bump(input exp_t e);
    if ((e.stall != '0) && (exp_sc != '1)) exp_sc = exp_sc + 1'b1;
    if ((e.flush != '0) && (exp_fc != '1)) exp_fc = exp_fc + 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    drive(mk(1'b1, TGT, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    #12;
    n_cmp++;
    if ({stall, flush, branch_taken_IFP, busy} !== 14'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got stall=%b flush=%b bt=%b busy=%b, expected all zero",
               stall, flush, branch_taken_IFP, busy);
    end
    n_cmp++;
    if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
      n_err++;
      $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt);
    end
    exp_sc = '0;
    exp_fc = '0;
    drive('0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b0, '0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b0));
    st.push_back('0); xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL load_use[%0d]: got stall=%b flush=%b bt=%b tgt=%h busy=%b, expected stall=%b flush=%b bt=%b tgt=%h busy=%b",
                 i, got.stall, got.flush, got.bt, got.tgt, got.busy, e.stall, e.flush, e.bt, e.tgt, e.busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((stall_cnt !== exp_sc) || (flush_cnt !== exp_fc)) begin
      n_err++;
      $display("[TB] FAIL load_use_cnt: got %0d/%0d, expected %0d/%0d", stall_cnt, flush_cnt, exp_sc, exp_fc);
    end
  endtask

  task automatic test_no_hazard();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    st.push_back(mk(1'b0, '0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(1'b0, '0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0));
    st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL no_hazard[%0d]: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
                 i, got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((stall_cnt !== exp_sc) || (flush_cnt !== exp_fc)) begin
      n_err++;
      $display("[TB] FAIL no_hazard_cnt: got %0d/%0d, expected %0d/%0d", stall_cnt, flush_cnt, exp_sc, exp_fc);
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b1, TGT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    xs.push_back(ex(ZERO, BRF, 1'b1, TGT, 1'b0));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL branch[%0d]: got stall=%b flush=%b bt=%b tgt=%h busy=%b, expected stall=%b flush=%b bt=%b tgt=%h busy=%b",
                 i, got.stall, got.flush, got.bt, got.tgt, got.busy, e.stall, e.flush, e.bt, e.tgt, e.busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((stall_cnt !== exp_sc) || (flush_cnt !== exp_fc)) begin
      n_err++;
      $display("[TB] FAIL branch_cnt: got %0d/%0d, expected %0d/%0d", stall_cnt, flush_cnt, exp_sc, exp_fc);
    end
  endtask

  task automatic test_memw_branch();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    for (int i = 0; i < 4; i++) begin
      st.push_back(mk(1'b1, TGT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      xs.push_back(ex(ALL, ZERO, 1'b0, TGT, (i != 0)));
    end
    st.push_back(mk(1'b1, TGT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    xs.push_back(ex(ZERO, BRF, 1'b1, TGT, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL memw_branch[%0d]: got stall=%b flush=%b bt=%b tgt=%h busy=%b, expected stall=%b flush=%b bt=%b tgt=%h busy=%b",
                 i, got.stall, got.flush, got.bt, got.tgt, got.busy, e.stall, e.flush, e.bt, e.tgt, e.busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((stall_cnt !== exp_sc) || (flush_cnt !== exp_fc)) begin
      n_err++;
      $display("[TB] FAIL memw_branch_cnt: got %0d/%0d, expected %0d/%0d", stall_cnt, flush_cnt, exp_sc, exp_fc);
    end
  endtask

  task automatic test_branch_lu();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b1, TGT, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    xs.push_back(ex(ZERO, BRF, 1'b1, TGT, 1'b0));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL branch_lu[%0d]: got stall=%b flush=%b bt=%b tgt=%h busy=%b, expected stall=%b flush=%b bt=%b tgt=%h busy=%b",
                 i, got.stall, got.flush, got.bt, got.tgt, got.busy, e.stall, e.flush, e.bt, e.tgt, e.busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b0, '0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0));
    xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b0));
    st.push_back(mk(1'b0, '0, 1'b1, 5'd12, 5'd12, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL back_to_back[%0d]: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
                 i, got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memw_resume();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b0, '0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b0));
    st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    xs.push_back(ex(ALL, ZERO, 1'b0, '0, 1'b1));
    st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    xs.push_back(ex(ALL, ZERO, 1'b0, '0, 1'b1));
    st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    xs.push_back(ex(FE, LUF, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL memw_resume[%0d]: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
                 i, got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    for (int i = 0; i < 20; i++) begin
      st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      xs.push_back(ex(ALL, ZERO, 1'b0, '0, (i != 0)));
    end
    st.push_back(mk(1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b1));
    st.push_back('0); xs.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL saturation[%0d]: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
                 i, got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((stall_cnt !== 4'd15) || (flush_cnt !== exp_fc)) begin
      n_err++;
      $display("[TB] FAIL saturation_cnt: got %0d/%0d, expected 15/%0d", stall_cnt, flush_cnt, exp_fc);
    end
  endtask

  task automatic test_reset_mid_redir();
    stim_t st[$];
    exp_t  xs[$];
    exp_t  got, e;
    st.push_back(mk(1'b1, TGT, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    xs.push_back(ex(ZERO, BRF, 1'b1, TGT, 1'b0));
    st.push_back('0); xs.push_back(ex(ZERO, RDF, 1'b0, '0, 1'b1));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]); sb.push_back(xs[i]); bump(xs[i]);
      @(negedge clk);
      got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("[TB] FAIL mid_redir[%0d]: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
                 i, got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
      end
      @(posedge clk); #1;
    end
    drive(mk(1'b1, TGT, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stall, flush, branch_taken_IFP, busy} !== 14'd0) begin
      n_err++;
      $display("[TB] FAIL mid_redir_reset: got stall=%b flush=%b bt=%b busy=%b, expected all zero",
               stall, flush, branch_taken_IFP, busy);
    end
    n_cmp++;
    if ((stall_cnt !== '0) || (flush_cnt !== '0)) begin
      n_err++;
      $display("[TB] FAIL mid_redir_reset_cnt: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt);
    end
    exp_sc = '0;
    exp_fc = '0;
    drive('0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(ex(ZERO, ZERO, 1'b0, '0, 1'b0));
    @(negedge clk);
    got = {stall, flush, branch_taken_IFP, branch_target_IFP, busy};
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("[TB] FAIL after_reset: got stall=%b flush=%b bt=%b busy=%b, expected stall=%b flush=%b bt=%b busy=%b",
               got.stall, got.flush, got.bt, got.busy, e.stall, e.flush, e.bt, e.busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_memw_branch();
    test_branch_lu();
    test_back_to_back();
    test_memw_resume();
    test_saturation();
    test_reset_mid_redir();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
